// File: rtl/alu_phase_sequencer.sv
// Step sequencer for the phase-clocked ALU: turns one accepted opcode into ordered
// single-cycle phase strobes, each followed by a write-back strobe, then a done pulse.
module alu_phase_sequencer #(
  parameter int CNT_W   = 16,
  parameter bit WB_HOLD = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ope,
  input  logic             ope_valid,
  output logic             ope_ready,
  input  logic             wb_hold,
  output logic [31:0]      ope_latched,
  output logic             step_4,
  output logic             step_6,
  output logic             step_8,
  output logic             wb_en,
  output logic [1:0]       wb_phase,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    IDLE, DEC, P4, W4, P6, W6, P8, W8, FIN
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] phase_set;
  logic       legal;
  logic       stall;

  // Phase set as {p8, p6, p4}; an empty set marks an unsupported opcode.
  function automatic logic [2:0] decode_phases(input logic [7:0] opcode);
    case (opcode)
      8'h55, 8'h53, 8'h5d, 8'hc3, 8'h6a, 8'h8b: return 3'b011;
      8'he8, 8'hc9:                             return 3'b111;
      8'h89, 8'hb8, 8'h83:                      return 3'b001;
      default:                                  return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] phase_code(input state_t s);
    case (s)
      W4:      return 2'd1;
      W6:      return 2'd2;
      W8:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign phase_set = decode_phases(ope_latched[31:24]);
  assign legal     = |phase_set;
  assign stall     = WB_HOLD && wb_hold;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ope_valid) state_next = DEC;
      DEC: begin
        if (phase_set[0])      state_next = P4;
        else if (phase_set[1]) state_next = P6;
        else if (phase_set[2]) state_next = P8;
        else                   state_next = FIN;
      end
      P4: state_next = W4;
      W4: begin
        if (stall)             state_next = W4;
        else if (phase_set[1]) state_next = P6;
        else if (phase_set[2]) state_next = P8;
        else                   state_next = FIN;
      end
      P6: state_next = W6;
      W6: begin
        if (stall)             state_next = W6;
        else if (phase_set[2]) state_next = P8;
        else                   state_next = FIN;
      end
      P8: state_next = W8;
      W8: begin
        if (stall) state_next = W8;
        else       state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  // and carry no combinational path from ope_valid or wb_hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ope_ready     <= 1'b1;
      ope_latched   <= '0;
      step_4        <= 1'b0;
      step_6        <= 1'b0;
      step_8        <= 1'b0;
      wb_en         <= 1'b0;
      wb_phase      <= 2'd0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      state     <= state_next;
      ope_ready <= (state_next == IDLE);
      step_4    <= (state_next == P4);
      step_6    <= (state_next == P6);
      step_8    <= (state_next == P8);
      wb_en     <= (state_next == W4) || (state_next == W6) || (state_next == W8);
      wb_phase  <= phase_code(state_next);
      done      <= (state_next == FIN);
      illegal   <= (state_next == FIN) && !legal;
      if (state == IDLE && ope_valid) ope_latched <= ope;
      if (state == FIN && legal) retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_phase_sequencer.sv
// Bench for alu_phase_sequencer: a per-instruction expected timeline is built from the
// opcode's phase count and chosen stall lengths, then compared cycle by cycle.
module tb_alu_phase_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ope;
  logic        ope_valid;
  logic        wb_hold;
  logic        ope_ready, step_4, step_6, step_8, wb_en, done, illegal;
  logic [31:0] ope_latched;
  logic [1:0]  wb_phase;
  logic [15:0] retired_count;
  logic        n_ope_ready, n_step_4, n_step_6, n_step_8, n_wb_en, n_done, n_illegal;
  logic [31:0] n_ope_latched;
  logic [1:0]  n_wb_phase;
  logic [3:0]  n_retired_count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  alu_phase_sequencer #(.CNT_W(16), .WB_HOLD(1'b1)) dut (
    .clock(clock), .reset(reset), .ope(ope), .ope_valid(ope_valid), .ope_ready(ope_ready),
    .wb_hold(wb_hold), .ope_latched(ope_latched), .step_4(step_4), .step_6(step_6),
    .step_8(step_8), .wb_en(wb_en), .wb_phase(wb_phase), .done(done), .illegal(illegal),
    .retired_count(retired_count)
  );

  // Narrow-counter twin on the same stimulus, used to observe counter wrap-around.
  alu_phase_sequencer #(.CNT_W(4), .WB_HOLD(1'b1)) dut_narrow (
    .clock(clock), .reset(reset), .ope(ope), .ope_valid(ope_valid), .ope_ready(n_ope_ready),
    .wb_hold(wb_hold), .ope_latched(n_ope_latched), .step_4(n_step_4), .step_6(n_step_6),
    .step_8(n_step_8), .wb_en(n_wb_en), .wb_phase(n_wb_phase), .done(n_done),
    .illegal(n_illegal), .retired_count(n_retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Number of phases an opcode needs; the phase sets are always p4, then p6, then p8.
  function automatic int nphases(input logic [7:0] op);
    case (op)
      8'h55, 8'h53, 8'h5d, 8'hc3, 8'h6a, 8'h8b: return 2;
      8'he8, 8'hc9:                             return 3;
      8'h89, 8'hb8, 8'h83:                      return 1;
      default:                                  return 0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, ope_ready}, 32'd1);
    chk({tag, "_steps"}, {29'd0, step_8, step_6, step_4}, 32'd0);
    chk({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
    chk({tag, "_wb_phase"}, {30'd0, wb_phase}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  // Starts in an IDLE cycle, offers word, follows it to completion and ends one cycle after done.
  task automatic run_instr(input logic [31:0] word, input int h4, input int h6, input int h8);
    int e_step[48];
    int e_wb[48];
    int e_done[48];
    int e_ill[48];
    int hin[48];
    int hs[3];
    int np;
    int idx;
    int n;
    hs[0] = h4; hs[1] = h6; hs[2] = h8;
    np = nphases(word[31:24]);
    for (int i = 0; i < 48; i++) begin
      e_step[i] = 0; e_wb[i] = 0; e_done[i] = 0; e_ill[i] = 0; hin[i] = -1;
    end
    idx = 2;
    if (np == 0) begin
      e_done[2] = 1;
      e_ill[2]  = 1;
      n = 2;
    end else begin
      for (int p = 0; p < np; p++) begin
        e_step[idx] = p + 1;
        idx++;
        for (int j = 0; j < hs[p]; j++) begin
          e_wb[idx] = p + 1;
          hin[idx]  = 1;
          idx++;
        end
        e_wb[idx] = p + 1;
        hin[idx]  = 0;
        idx++;
      end
      e_done[idx] = 1;
      n = idx;
    end

    chk("ready_at_accept", {31'd0, ope_ready}, 32'd1);
    ope       = word;
    ope_valid = 1'b1;
    wb_hold   = 1'($urandom % 2);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk($sformatf("step4_c%0d", k), {31'd0, step_4}, {31'd0, e_step[k] == 1});
      chk($sformatf("step6_c%0d", k), {31'd0, step_6}, {31'd0, e_step[k] == 2});
      chk($sformatf("step8_c%0d", k), {31'd0, step_8}, {31'd0, e_step[k] == 3});
      chk($sformatf("wb_en_c%0d", k), {31'd0, wb_en}, {31'd0, e_wb[k] != 0});
      chk($sformatf("wb_phase_c%0d", k), {30'd0, wb_phase}, 32'(e_wb[k]));
      chk($sformatf("done_c%0d", k), {31'd0, done}, 32'(e_done[k]));
      chk($sformatf("illegal_c%0d", k), {31'd0, illegal}, 32'(e_ill[k]));
      chk($sformatf("busy_ready_c%0d", k), {31'd0, ope_ready}, 32'd0);
      chk($sformatf("latched_c%0d", k), ope_latched, word);
      ope       = $urandom;
      ope_valid = 1'($urandom % 2);
      wb_hold   = (hin[k] < 0) ? 1'($urandom % 2) : 1'(hin[k]);
    end
    if (np > 0) model_count = (model_count + 1) % 65536;
    tick();
    check_idle_outputs("after_done");
    chk("retired_count", {16'd0, retired_count}, 32'(model_count));
    chk("retired_count_narrow", {28'd0, n_retired_count}, 32'(model_count % 16));
    chk("latched_hold", ope_latched, word);
    ope_valid = 1'b0;
    wb_hold   = 1'b0;
  endtask

  logic [7:0] legal_ops[11];

  initial begin
    legal_ops = '{8'h55, 8'h53, 8'h5d, 8'hc3, 8'h6a, 8'h8b, 8'he8, 8'hc9, 8'h89, 8'hb8, 8'h83};
    reset = 1'b1; ope = 32'hdeadbeef; ope_valid = 1'b1; wb_hold = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    chk("reset_latched", ope_latched, 32'd0);
    chk("reset_count", {16'd0, retired_count}, 32'd0);
    reset = 1'b0; ope_valid = 1'b0;
    tick();
    check_idle_outputs("idle");

    run_instr(32'h55123456, 0, 0, 0);
    run_instr(32'he8eeffff, 0, 0, 0);
    run_instr(32'hb8010203, 0, 0, 0);
    run_instr(32'h89abcdef, 0, 0, 0);
    run_instr(32'hff000000, 0, 0, 0);
    run_instr(32'he8000000, 0, 3, 0);

    // Reset lands while c9 is committing phase 6.
    chk("mid_ready", {31'd0, ope_ready}, 32'd1);
    ope = 32'hc9000000; ope_valid = 1'b1; wb_hold = 1'b0;
    tick();
    ope_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mid_w6_wb_en", {31'd0, wb_en}, 32'd1);
    chk("mid_w6_phase", {30'd0, wb_phase}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_count = 0;
    check_idle_outputs("mid_reset");
    chk("mid_reset_count", {16'd0, retired_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle_outputs($sformatf("post_reset_c%0d", i));
    end

    for (int t = 0; t < 40; t++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom % 5 != 0) w[31:24] = legal_ops[$urandom % 11];
      run_instr(w, ($urandom % 2) ? 0 : int'($urandom_range(1, 3)),
                ($urandom % 2) ? 0 : int'($urandom_range(1, 3)),
                ($urandom % 2) ? 0 : int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
